fsqrt_wb_ctrl: RTL and testbench



---
 rtl/fsqrt_wb_ctrl.sv | 149 ++++++++++++++
 tb/tb_fsqrt_wb_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_wb_ctrl.sv
// fsqrt_wb_ctrl: issue/write-back controller for the iterative FP sqrt unit.
// Optional ID bypass on the grant cycle: define FSQRT_WB_FWD_EN.
//
// Ports:
//   clk, clr         clock, synchronous active-high reset
//   ena              pipeline enable; low freezes state, counter, captures
//   fsqrt_req/rd     fsqrt held in ID and its destination
//   use_fs/id_fs     ID reads fs
//   use_ft/id_ft     ID reads ft
//   id_wfpr/id_fd    ID writes an FP register
//   sqrt_s           sqrt unit result, valid when the counter expires
//   wb_req/wb_grant  FP regfile write-port arbitration
//   fp_we/wn/wd      regfile write enable, index, data
//   issue            fsqrt accepted (starts sqrt unit)
//   stall            freeze IF/ID
//   busy             an fsqrt is pending
//   fwd_fs/ft, fwd_d bypass selects and data (FSQRT_WB_FWD_EN only)
module fsqrt_wb_ctrl #(
   parameter int SQRT_LAT = 16,
   parameter int RD_W     = 5
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            ena,
   input  logic            fsqrt_req,
   input  logic [RD_W-1:0] fsqrt_rd,
   input  logic            use_fs,
   input  logic [RD_W-1:0] id_fs,
   input  logic            use_ft,
   input  logic [RD_W-1:0] id_ft,
   input  logic            id_wfpr,
   input  logic [RD_W-1:0] id_fd,
   input  logic [31:0]     sqrt_s,
   output logic            wb_req,
   input  logic            wb_grant,
   output logic            fp_we,
   output logic [RD_W-1:0] fp_wn,
   output logic [31:0]     fp_wd,
   output logic            issue,
   output logic            stall,
`ifdef FSQRT_WB_FWD_EN
   output logic            fwd_fs,
   output logic            fwd_ft,
   output logic [31:0]     fwd_d,
`endif
   output logic            busy
);

   localparam int CW = 5;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      WB
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [RD_W-1:0] pend_rd, pend_nx;
   logic [31:0]     res_q, res_nx;
   logic [RD_W-1:0] wn_q;
   logic [31:0]     wd_q;

   logic pv;
   logic hit_fs;
   logic hit_ft;
   logic hit_fd;
   logic raw;

   // hazard detection against the pending destination
   always_comb begin
      pv     = (state != IDLE);
      hit_fs = pv & use_fs & (id_fs == pend_rd);
      hit_ft = pv & use_ft & (id_ft == pend_rd);
      hit_fd = pv & id_wfpr & (id_fd == pend_rd);
`ifdef FSQRT_WB_FWD_EN
      // the result is on the write port this cycle, so a reader can bypass
      fwd_fs = (state == WB) & wb_grant & hit_fs;
      fwd_ft = (state == WB) & wb_grant & hit_ft;
      fwd_d  = res_q;
      raw    = (hit_fs & ~fwd_fs) | (hit_ft & ~fwd_ft);
`else
      raw    = hit_fs | hit_ft;
`endif
      stall  = (fsqrt_req & pv) | raw | hit_fd;
      busy   = pv;
   end

   // write port; index/data hold their last written values between writes
   always_comb begin
      wb_req = (state == WB) & ~clr;
      fp_we  = wb_req & wb_grant;
      fp_wn  = fp_we ? pend_rd : wn_q;
      fp_wd  = fp_we ? res_q : wd_q;
      issue  = (state == IDLE) & fsqrt_req & ~stall & ena & ~clr;
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pend_nx  = pend_rd;
      res_nx   = res_q;
      unique case (state)
         IDLE: begin
            if (issue) begin
               pend_nx  = fsqrt_rd;
               cnt_nx   = CW'(SQRT_LAT - 1);
               state_nx = RUN;
            end
         end
         RUN: begin
            if (ena) begin
               if (cnt == '0) begin
                  res_nx   = sqrt_s;
                  state_nx = WB;
               end else begin
                  cnt_nx = cnt - CW'(1);
               end
            end
         end
         WB: begin
            // grant wait is independent of ena
            if (wb_grant) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state   <= IDLE;
         cnt     <= '0;
         pend_rd <= '0;
         res_q   <= '0;
         wn_q    <= '0;
         wd_q    <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         pend_rd <= pend_nx;
         res_q   <= res_nx;
         if (fp_we) begin
            wn_q <= pend_rd;
            wd_q <= res_q;
         end
      end
   end

endmodule

// File: tb/tb_fsqrt_wb_ctrl.sv
// tb_fsqrt_wb_ctrl: directed bench for fsqrt_wb_ctrl (SQRT_LAT=16, RD_W=5).
// Hazard vectors come from a table; latency, grant, reset, ena are sequences.
module tb_fsqrt_wb_ctrl;

   logic        clk = 1'b0;
   logic        clr, ena, fsqrt_req;
   logic [4:0]  fsqrt_rd;
   logic        use_fs, use_ft, id_wfpr;
   logic [4:0]  id_fs, id_ft, id_fd;
   logic [31:0] sqrt_s;
   logic        wb_req, wb_grant, fp_we;
   logic [4:0]  fp_wn;
   logic [31:0] fp_wd;
   logic        issue, stall, busy;
`ifdef FSQRT_WB_FWD_EN
   logic        fwd_fs, fwd_ft;
   logic [31:0] fwd_d;
`endif

   int pass = 0;
   int total = 0;

   fsqrt_wb_ctrl #(.SQRT_LAT(16), .RD_W(5)) dut (
      .clk(clk), .clr(clr), .ena(ena),
      .fsqrt_req(fsqrt_req), .fsqrt_rd(fsqrt_rd),
      .use_fs(use_fs), .id_fs(id_fs),
      .use_ft(use_ft), .id_ft(id_ft),
      .id_wfpr(id_wfpr), .id_fd(id_fd),
      .sqrt_s(sqrt_s),
      .wb_req(wb_req), .wb_grant(wb_grant),
      .fp_we(fp_we), .fp_wn(fp_wn), .fp_wd(fp_wd),
      .issue(issue), .stall(stall),
`ifdef FSQRT_WB_FWD_EN
      .fwd_fs(fwd_fs), .fwd_ft(fwd_ft), .fwd_d(fwd_d),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       req;
      logic       ufs;
      logic [4:0] fs;
      logic       uft;
      logic [4:0] ft;
      logic       wfpr;
      logic [4:0] fd;
      logic       x_stall;
      logic       x_issue;
   } hz_t;

   hz_t hz[9];

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic idle_id;
      fsqrt_req = 1'b0;
      use_fs = 1'b0; id_fs = '0;
      use_ft = 1'b0; id_ft = '0;
      id_wfpr = 1'b0; id_fd = '0;
   endtask

   initial begin
      //        req ufs fs    uft ft    wfpr fd    stall issue
      hz[0] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
      hz[1] = '{1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0};
      hz[2] = '{1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
      hz[3] = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 1'b0};
      hz[4] = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
      hz[5] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0};
      hz[6] = '{1'b0, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0};
      hz[7] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0};
      hz[8] = '{1'b0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0};

      clr = 1'b1; ena = 1'b1; wb_grant = 1'b1;
      fsqrt_rd = '0; sqrt_s = '0;
      idle_id();
      tick();
      tick();
      clr = 1'b0;
      #1;
      chk("rst busy", busy, 0);
      chk("rst wb_req", wb_req, 0);
      chk("rst fp_we", fp_we, 0);
      chk("rst fp_wn", fp_wn, 0);
      chk("rst fp_wd", fp_wd, 0);
      chk("rst stall", stall, 0);
      chk("rst issue", issue, 0);
      tick();

      // single op rd=7, grant tied high, hazard table during RUN
      fsqrt_req = 1'b1; fsqrt_rd = 5'd7;
      #1;
      chk("op1 issue", issue, 1);
      chk("op1 stall", stall, 0);
      tick();
      fsqrt_req = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         sqrt_s = (c == 16) ? 32'h40000000 : (32'hDEAD0000 | 32'(c));
         if (c <= 9) begin
            fsqrt_req = hz[c-1].req;
            use_fs = hz[c-1].ufs; id_fs = hz[c-1].fs;
            use_ft = hz[c-1].uft; id_ft = hz[c-1].ft;
            id_wfpr = hz[c-1].wfpr; id_fd = hz[c-1].fd;
         end else begin
            idle_id();
         end
         #1;
         chk($sformatf("op1 busy c%0d", c), busy, 1);
         chk($sformatf("op1 fp_we c%0d", c), fp_we, 0);
         if (c <= 9) begin
            chk($sformatf("hz%0d stall", c-1), stall, hz[c-1].x_stall);
            chk($sformatf("hz%0d issue", c-1), issue, hz[c-1].x_issue);
         end
         tick();
      end
      idle_id();
      sqrt_s = 32'hFFFFFFFF;
      use_fs = 1'b1; id_fs = 5'd7;
      #1;
      chk("op1 wb_req", wb_req, 1);
      chk("op1 fp_we", fp_we, 1);
      chk("op1 fp_wn", fp_wn, 7);
      chk("op1 fp_wd", fp_wd, 32'h40000000);
      chk("op1 busy17", busy, 1);
`ifdef FSQRT_WB_FWD_EN
      chk("fwd stall", stall, 0);
      chk("fwd fs", fwd_fs, 1);
      chk("fwd d", fwd_d, 32'h40000000);
`else
      chk("raw wb stall", stall, 1);
`endif
      tick();
      #1;
      chk("op1 done busy", busy, 0);
      chk("raw release", stall, 0);
      chk("op1 done fp_we", fp_we, 0);
      chk("hold fp_wn", fp_wn, 7);
      chk("hold fp_wd", fp_wd, 32'h40000000);
      idle_id();
      tick();

      // grant delayed 3 WB cycles, then a new fsqrt hits the grant cycle
      wb_grant = 1'b0;
      fsqrt_req = 1'b1; fsqrt_rd = 5'd3;
      #1;
      chk("op2 issue", issue, 1);
      tick();
      fsqrt_req = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         sqrt_s = 32'h12340000 + 32'(c);
         #1;
         chk($sformatf("op2 busy c%0d", c), busy, 1);
         tick();
      end
      for (int c = 17; c <= 19; c++) begin
         sqrt_s = '0;
         #1;
         chk($sformatf("op2 wb_req c%0d", c), wb_req, 1);
         chk($sformatf("op2 fp_we c%0d", c), fp_we, 0);
         chk($sformatf("op2 fp_wn c%0d", c), fp_wn, 7);
         chk($sformatf("op2 fp_wd c%0d", c), fp_wd, 32'h40000000);
         tick();
      end
      wb_grant = 1'b1;
      fsqrt_req = 1'b1; fsqrt_rd = 5'd4;
      #1;
      chk("op2 wb_req c20", wb_req, 1);
      chk("op2 fp_we c20", fp_we, 1);
      chk("op2 fp_wn c20", fp_wn, 3);
      chk("op2 fp_wd c20", fp_wd, 32'h12340010);
      chk("wb struct stall", stall, 1);
      chk("wb struct issue", issue, 0);
      tick();
      #1;
      chk("op3 busy0", busy, 0);
      chk("op3 stall0", stall, 0);
      chk("op3 issue", issue, 1);
      tick();
      fsqrt_req = 1'b0;

      // clr mid-RUN abandons op3 (rd=4)
      for (int c = 1; c <= 5; c++) tick();
      clr = 1'b1;
      tick();
      tick();
      clr = 1'b0;
      #1;
      chk("clr busy", busy, 0);
      chk("clr wb_req", wb_req, 0);
      chk("clr fp_we", fp_we, 0);
      chk("clr fp_wn", fp_wn, 0);
      chk("clr fp_wd", fp_wd, 0);
      for (int c = 0; c < 20; c++) begin
         tick();
         #1;
         chk($sformatf("abandon fp_we c%0d", c), fp_we, 0);
         chk($sformatf("abandon wb_req c%0d", c), wb_req, 0);
      end

      // ena low blocks issue
      fsqrt_req = 1'b1; fsqrt_rd = 5'd12; ena = 1'b0;
      #1;
      chk("ena0 issue", issue, 0);
      tick();
      #1;
      chk("ena0 busy", busy, 0);
      ena = 1'b1;
      #1;
      chk("op4 issue", issue, 1);
      tick();
      fsqrt_req = 1'b0;

      // ena low cycles 6..10 delays WB from cycle 17 to 22
      for (int c = 1; c <= 22; c++) begin
         ena = !(c >= 6 && c <= 10);
         sqrt_s = ena ? (32'h55000000 + 32'(c)) : 32'hBAD00000;
         #1;
         chk($sformatf("op4 wb_req c%0d", c), wb_req, (c == 22));
         chk($sformatf("op4 fp_we c%0d", c), fp_we, (c == 22));
         if (c == 22) begin
            chk("op4 fp_wn", fp_wn, 12);
            chk("op4 fp_wd", fp_wd, 32'h55000015);
         end
         tick();
      end
      #1;
      chk("op4 done busy", busy, 0);

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
